// File: rtl/alu_exec_ctrl_pkg.sv
// Shared encodings for the ALU execute/writeback sequencer.
package alu_exec_ctrl_pkg;

   localparam logic [1:0] COND_ALWAYS = 2'b00;
   localparam logic [1:0] COND_ZERO   = 2'b01;
   localparam logic [1:0] COND_CARRY  = 2'b10;
   localparam logic [1:0] COND_RSVD   = 2'b11;

   localparam logic ALU_OP_ADD  = 1'b0;
   localparam logic ALU_OP_NAND = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EVAL,
      ST_WB
   } state_e;

   // Reserved encoding behaves as unconditional.
   function automatic logic cond_pass(input logic [1:0] cond, input logic c, input logic z);
      logic ok;
      ok = 1'b1;
      case (cond)
         COND_CARRY: ok = c;
         COND_ZERO:  ok = z;
         default:    ok = 1'b1;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// Issue, ALU and writeback bundles between decode, ALU and register-file controller.
interface alu_exec_ctrl_if #(
   parameter int WIDTH    = 16,
   parameter int REG_BITS = 3
);
   logic                issue_valid;
   logic                issue_ready;
   logic                issue_op_nand;
   logic [1:0]          issue_cond;
   logic [WIDTH-1:0]    issue_a;
   logic [WIDTH-1:0]    issue_b;
   logic [REG_BITS-1:0] issue_dest;

   logic [WIDTH-1:0]    alu_in1;
   logic [WIDTH-1:0]    alu_in2;
   logic                alu_op;
   logic [WIDTH-1:0]    alu_out;
   logic                alu_carry;
   logic                alu_zero;

   logic                wb_valid;
   logic                wb_ready;
   logic                wb_en;
   logic [WIDTH-1:0]    wb_data;
   logic [REG_BITS-1:0] wb_dest;

   modport slave (
      input  issue_valid, issue_op_nand, issue_cond, issue_a, issue_b, issue_dest,
      output issue_ready,
      output alu_in1, alu_in2, alu_op,
      input  alu_out, alu_carry, alu_zero,
      output wb_valid, wb_en, wb_data, wb_dest,
      input  wb_ready
   );

   modport master (
      output issue_valid, issue_op_nand, issue_cond, issue_a, issue_b, issue_dest,
      input  issue_ready,
      input  alu_in1, alu_in2, alu_op,
      output alu_out, alu_carry, alu_zero,
      input  wb_valid, wb_en, wb_data, wb_dest,
      output wb_ready
   );
endinterface

// File: rtl/alu_exec_ctrl_sat_counter.sv
// Saturating event counter; holds at all-ones.
module sat_counter #(
   parameter int CNT_BITS = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                inc,
   output logic [CNT_BITS-1:0] count
);
   logic [CNT_BITS-1:0] count_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else if (inc && (count_q != '1)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count = count_q;
endmodule

// File: rtl/alu_exec_ctrl.sv
// ALU sequencer: issue capture, one-cycle evaluation, held writeback record, C/Z flags.
module alu_exec_ctrl
   import alu_exec_ctrl_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int REG_BITS = 3,
   parameter int CNT_BITS = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   alu_exec_ctrl_if.slave      bus,
   output logic                carry_flag,
   output logic                zero_flag,
   output logic [CNT_BITS-1:0] exec_count,
   output logic [CNT_BITS-1:0] skip_count
);
   state_e              state_q, state_d;
   logic [WIDTH-1:0]    a_q, b_q;
   logic                op_q;
   logic [1:0]          cond_q;
   logic [REG_BITS-1:0] dest_q;
   logic                wb_en_q;
   logic [WIDTH-1:0]    wb_data_q;
   logic [REG_BITS-1:0] wb_dest_q;
   logic                carry_q, zero_q;
   logic                cond_ok;
   logic                exec_inc, skip_inc;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      exec_inc = 1'b0;
      skip_inc = 1'b0;
      cond_ok  = cond_pass(cond_q, carry_q, zero_q);
      case (state_q)
         ST_IDLE: if (bus.issue_valid) state_d = ST_EVAL;
         ST_EVAL: begin
            state_d  = ST_WB;
            exec_inc = cond_ok;
            skip_inc = !cond_ok;
         end
         ST_WB:   if (bus.wb_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= ALU_OP_ADD;
         cond_q    <= COND_ALWAYS;
         dest_q    <= '0;
         wb_en_q   <= 1'b0;
         wb_data_q <= '0;
         wb_dest_q <= '0;
         carry_q   <= 1'b0;
         zero_q    <= 1'b0;
      end else begin
         if (state_q == ST_IDLE && bus.issue_valid) begin
            a_q    <= bus.issue_a;
            b_q    <= bus.issue_b;
            op_q   <= bus.issue_op_nand;
            cond_q <= bus.issue_cond;
            dest_q <= bus.issue_dest;
         end
         if (state_q == ST_EVAL) begin
            wb_dest_q <= dest_q;
            if (exec_inc) begin
               wb_en_q   <= 1'b1;
               wb_data_q <= bus.alu_out;
               zero_q    <= bus.alu_zero;
               // NAND family leaves the carry flag untouched.
               if (op_q == ALU_OP_ADD) carry_q <= bus.alu_carry;
            end else begin
               wb_en_q   <= 1'b0;
               wb_data_q <= '0;
            end
         end
      end
   end

   assign bus.issue_ready = (state_q == ST_IDLE);
   assign bus.wb_valid    = (state_q == ST_WB);
   assign bus.alu_in1     = a_q;
   assign bus.alu_in2     = b_q;
   assign bus.alu_op      = op_q;
   assign bus.wb_en       = wb_en_q;
   assign bus.wb_data     = wb_data_q;
   assign bus.wb_dest     = wb_dest_q;
   assign carry_flag      = carry_q;
   assign zero_flag       = zero_q;

   sat_counter #(.CNT_BITS(CNT_BITS)) u_exec_cnt (
      .clk(clk), .reset_n(reset_n), .inc(exec_inc), .count(exec_count)
   );

   sat_counter #(.CNT_BITS(CNT_BITS)) u_skip_cnt (
      .clk(clk), .reset_n(reset_n), .inc(skip_inc), .count(skip_count)
   );
endmodule
